pipe_run_ctrl: RTL and testbench
================================

# pipe_run_ctrl

Run/halt sequencer for the 3-stage pipelined processor (IF/ID, ID/EX, EX/WB registers). It gates PC update and IF/ID loading, inserts bubbles to flush on jumps, and drains the pipeline on halt, breakpoint or single-step. It keeps a per-stage valid shadow and exposes cycle and retire counters. It sits beside the processor core and drives its enable and bubble inputs.

## Interface
- PC_W, 8, PC / breakpoint address width
- DRAIN_CYCLES, 3, cycles needed for in-flight instructions to reach write-back
- CNT_W, 16, width of the saturating performance counters
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  pulse: begin or resume execution
- halt_req  in  1  pulse: stop fetching and drain
- step  in  1  pulse: execute exactly one instruction (from HALTED only)
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint PC
- pc  in  PC_W  current fetch PC from the core
- id_opcode  in  2  opcode bits [7:6] of the IF/ID instruction
- cnt_clr  in  1  synchronous clear of both counters
- pc_en  out  1  PC register may advance
- fetch_valid  out  1  1 = IF/ID loads the fetched instruction; 0 = IF/ID loads NOP 8'h80
- flush  out  1  jump in ID; IF/ID loads NOP at next edge
- busy  out  1  state is RUN, STEP or DRAIN
- halted  out  1  state is HALTED
- done  out  1  one-cycle pulse on entering HALTED
- cycle_cnt  out  CNT_W  cycles spent in RUN, STEP or DRAIN
- retire_cnt  out  CNT_W  instructions leaving EX/WB as valid

## Operation
- States are IDLE, RUN, STEP, DRAIN and HALTED. Reset enters IDLE.
- IDLE: start -> RUN.
- RUN: if halt_req, or (bp_en and pc == bp_addr and not bp_skip), go to DRAIN.
- STEP: lasts exactly one cycle, then goes to DRAIN.
- DRAIN: a down-counter is loaded with DRAIN_CYCLES-1. The state goes to HALTED when the counter reaches 0.
- HALTED: start -> RUN with bp_skip set. step -> STEP with bp_skip set.
- bp_skip clears after the first fetch cycle, so resuming from a breakpoint does not re-trap on the same PC.
- Moore outputs:
  - pc_en = fetch_valid = (RUN with no halt/breakpoint condition this cycle) or STEP.
  - The breakpointed instruction is not fetched.
- Valid shadow v[2:0]:
  - v[0] <= fetch_valid & ~flush
  - v[1] <= v[0]
  - v[2] <= v[1]
- flush = v[0] & (id_opcode == 2'b11). In the same cycle fetch_valid is forced to 0, because the fetched word is the jump target being redirected.
- retire_cnt increments when v[2] = 1. Jumps retire as valid.
- Both counters saturate at all-ones.
- cnt_clr overrides increment.
- Simultaneous events:
  - halt_req and start in the same cycle: halt_req wins.
  - step in RUN or DRAIN: ignored.
  - start in RUN or DRAIN: ignored.
  - halt_req in HALTED or IDLE: ignored.
  - A jump in ID while entering DRAIN: flush still asserts.

## Timing
- Reset values:
  - pc_en, fetch_valid, flush, busy, halted, done = 0
  - cycle_cnt = retire_cnt = 0
  - v = 0
  - drain counter = 0
  - bp_skip = 0
- Control inputs are sampled at the rising edge; the state changes at that edge.
- start at edge N: pc_en = 1 during cycle N+1.
- halt_req at edge N: pc_en = 0 from cycle N+1. done pulses DRAIN_CYCLES cycles later.
- Step: exactly one pc_en cycle, then DRAIN_CYCLES cycles of DRAIN, then done.
- flush is combinational from registered v[0] and the IF/ID opcode (same cycle).
- Reset asserted mid-operation: all outputs go low immediately (asynchronous), and no done pulse is issued.

## Structure
- Shared package proc_ctrl_pkg holds:
  - state enum
  - OPC_JMP = 2'b11
  - NOP_INSTR = 8'h80
- Sub-module sat_counter (parameter W; inputs clk, reset, clr, inc; output q) is instantiated twice, for cycle_cnt and retire_cnt.

## Test plan
- **Reset then start:**
  - Stimulus: release reset, pulse start.
  - Required: pc_en = 1 one cycle later; after 6 instructions with no jump, retire_cnt = 6 once v drains.
- **Jump flush:**
  - Stimulus: id_opcode = 2'b11 with v[0] = 1.
  - Required: flush = 1 and fetch_valid = 0 that cycle; v[0] = 0 next cycle; retire_cnt increases by 1 for the jump and by 0 for the bubble.
- **Breakpoint:**
  - Stimulus: bp_en = 1, bp_addr = 5; pc reaches 5.
  - Required: pc_en = 0 that cycle; done after 3 cycles. Then pulse start: pc_en = 1 at pc = 5 with no re-trap.
- **Single step from HALTED:**
  - Stimulus: pulse step.
  - Required: exactly one pc_en cycle; retire_cnt increases by 1; done 3 cycles after STEP.
- **Simultaneous and ignored events:**
  - Stimulus: start and halt_req together in HALTED.
  - Required: stays HALTED.
  - Stimulus: step during RUN.
  - Required: no effect.
- **Reset and saturation:**
  - Stimulus: reset during DRAIN.
  - Required: all outputs 0 immediately, no done pulse.
  - Stimulus: CNT_W = 4 with a long run.
  - Required: cycle_cnt holds at 15; cnt_clr returns it to 0.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor run/halt control slice.
// Keeps the state encoding and instruction constants in one place.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [1:0] OPC_JMP   = 2'b11;
    localparam logic [7:0] NOP_INSTR = 8'h80;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over increment; the count holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/halt sequencer for the 3-stage pipeline: fetch gating, jump flush,
// drain on halt/breakpoint/step, valid shadow and performance counters.
module pipe_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic [1:0]       id_opcode,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             fetch_valid,
    output logic             flush,
    output logic             busy,
    output logic             halted,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

    state_t            state;
    logic [DCNT_W-1:0] dcnt;
    logic              bp_skip;
    logic [2:0]        v;
    logic              done_q;
    logic              bp_hit;
    logic              stop;
    logic              fetch_ok;

    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
    assign stop   = halt_req || bp_hit;

    // The trapping instruction is never fetched, so stop gates fetch now.
    assign fetch_ok = ((state == ST_RUN) && !stop) || (state == ST_STEP);

    assign flush       = v[0] && (id_opcode == OPC_JMP);
    assign pc_en       = fetch_ok;
    assign fetch_valid = fetch_ok && !flush;
    assign busy        = (state == ST_RUN) || (state == ST_STEP) ||
                         (state == ST_DRAIN);
    assign halted      = (state == ST_HALTED);
    assign done        = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            dcnt    <= '0;
            bp_skip <= 1'b0;
            v       <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            v      <= {v[1:0], fetch_valid};
            unique case (state)
                ST_IDLE: begin
                    if (start && !halt_req) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    bp_skip <= 1'b0;
                    if (stop) begin
                        state <= ST_DRAIN;
                        dcnt  <= DRAIN_LOAD;
                    end
                end
                ST_STEP: begin
                    bp_skip <= 1'b0;
                    state   <= ST_DRAIN;
                    dcnt    <= DRAIN_LOAD;
                end
                ST_DRAIN: begin
                    if (dcnt == '0) begin
                        state  <= ST_HALTED;
                        done_q <= 1'b1;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                ST_HALTED: begin
                    // Resuming skips one breakpoint match on the halted PC.
                    if (start && !halt_req) begin
                        state   <= ST_RUN;
                        bp_skip <= 1'b1;
                    end else if (step) begin
                        state   <= ST_STEP;
                        bp_skip <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (busy),
        .q     (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (v[2]),
        .q     (retire_cnt)
    );

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: run, jump flush, breakpoint, step,
// ignored events, asynchronous reset and counter saturation.
module tb_pipe_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        step = 1'b0;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'd0;
    logic [7:0]  pc = 8'd0;
    logic [1:0]  id_opcode = 2'b00;
    logic        cnt_clr = 1'b0;
    logic        pc_en, fetch_valid, flush, busy, halted, done;
    logic [15:0] cycle_cnt, retire_cnt;

    logic        s_start = 1'b0;
    logic        s_clr = 1'b0;
    logic        s_pc_en, s_fv, s_flush, s_busy, s_halted, s_done;
    logic [3:0]  s_cycle, s_retire;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_run_ctrl #(.PC_W(8), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .step        (step),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .id_opcode   (id_opcode),
        .cnt_clr     (cnt_clr),
        .pc_en       (pc_en),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .busy        (busy),
        .halted      (halted),
        .done        (done),
        .cycle_cnt   (cycle_cnt),
        .retire_cnt  (retire_cnt)
    );

    pipe_run_ctrl #(.PC_W(8), .DRAIN_CYCLES(3), .CNT_W(4)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .start       (s_start),
        .halt_req    (1'b0),
        .step        (1'b0),
        .bp_en       (1'b0),
        .bp_addr     (8'd0),
        .pc          (8'd0),
        .id_opcode   (2'b00),
        .cnt_clr     (s_clr),
        .pc_en       (s_pc_en),
        .fetch_valid (s_fv),
        .flush       (s_flush),
        .busy        (s_busy),
        .halted      (s_halted),
        .done        (s_done),
        .cycle_cnt   (s_cycle),
        .retire_cnt  (s_retire)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_done", done, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_retire", retire_cnt, 0);
        tick;
        tick;
        reset = 1'b1;
        tick;
        chk("idle_pc_en", pc_en, 0);

        // six straight-line instructions, then halt
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_pc_en", pc_en, 1);
        chk("start_busy", busy, 1);
        repeat (6) tick;
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        chk("drain_pc_en", pc_en, 0);
        chk("drain_busy", busy, 1);
        tick;
        tick;
        chk("drain_no_done", done, 0);
        chk("drain_not_halted", halted, 0);
        tick;
        chk("halt_done", done, 1);
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("run_retire6", retire_cnt, 6);
        chk("run_cycle10", cycle_cnt, 10);
        tick;
        chk("done_one_cycle", done, 0);

        // jump in ID: flush and bubble
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("jmp_first_fetch", fetch_valid, 1);
        tick;
        id_opcode = 2'b11;
        #1;
        chk("jmp_flush", flush, 1);
        chk("jmp_fetch_kill", fetch_valid, 0);
        chk("jmp_pc_en", pc_en, 1);
        tick;
        chk("bubble_no_flush", flush, 0);
        chk("bubble_fetch", fetch_valid, 1);
        id_opcode = 2'b00;
        tick;
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        chk("jmp_retired", retire_cnt, 7);
        tick;
        chk("bubble_not_retired", retire_cnt, 7);
        tick;
        tick;
        chk("jmp_done", done, 1);
        chk("jmp_retire8", retire_cnt, 8);

        // breakpoint at pc 5, then resume past it
        bp_en = 1'b1;
        bp_addr = 8'd5;
        pc = 8'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("bp_r1_pc_en", pc_en, 1);
        tick;
        pc = 8'd4;
        #1;
        chk("bp_r2_pc_en", pc_en, 1);
        tick;
        pc = 8'd5;
        #1;
        chk("bp_hit_pc_en", pc_en, 0);
        chk("bp_hit_fetch", fetch_valid, 0);
        tick;
        chk("bp_drain_pc_en", pc_en, 0);
        chk("bp_drain_busy", busy, 1);
        tick;
        tick;
        chk("bp_no_done_yet", done, 0);
        tick;
        chk("bp_done", done, 1);
        chk("bp_retire10", retire_cnt, 10);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("bp_resume_no_retrap", pc_en, 1);
        tick;
        pc = 8'd6;
        #1;
        chk("bp_resume_next", pc_en, 1);
        tick;
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        tick;
        tick;
        tick;
        chk("bp_resume_halted", halted, 1);
        chk("bp_resume_retire12", retire_cnt, 12);
        bp_en = 1'b0;
        pc = 8'd0;

        // single step
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("step_pc_en", pc_en, 1);
        chk("step_busy", busy, 1);
        tick;
        chk("step_one_only", pc_en, 0);
        chk("step_drain_busy", busy, 1);
        tick;
        tick;
        chk("step_no_done_yet", done, 0);
        tick;
        chk("step_done", done, 1);
        chk("step_retire13", retire_cnt, 13);

        // start with halt_req in HALTED, step in RUN
        start = 1'b1;
        halt_req = 1'b1;
        tick;
        start = 1'b0;
        halt_req = 1'b0;
        chk("both_stay_halted", halted, 1);
        chk("both_pc_en", pc_en, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        step = 1'b1;
        tick;
        step = 1'b0;
        chk("step_in_run_busy", busy, 1);
        chk("step_in_run_pc_en", pc_en, 1);
        tick;
        chk("step_in_run_still", pc_en, 1);

        // asynchronous reset during drain
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        tick;
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("arst_pc_en", pc_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_halted", halted, 0);
        chk("arst_done", done, 0);
        chk("arst_cycle", cycle_cnt, 0);
        chk("arst_retire", retire_cnt, 0);
        repeat (4) tick;
        chk("arst_no_done", done, 0);
        chk("arst_not_halted", halted, 0);
        reset = 1'b1;
        tick;

        // 4-bit counters saturate, then clear
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        repeat (20) tick;
        chk("sat_cycle", s_cycle, 15);
        chk("sat_retire", s_retire, 15);
        chk("idle_cycle_hold", cycle_cnt, 0);
        s_clr = 1'b1;
        tick;
        s_clr = 1'b0;
        chk("clr_cycle", s_cycle, 0);
        chk("clr_retire", s_retire, 0);
        tick;
        chk("after_clr_cycle", s_cycle, 1);
        chk("after_clr_retire", s_retire, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
